// File: rtl/sram_port_arbiter.sv
// Multi-port external SRAM arbiter with fixed-priority or round-robin grant,
// programmable strobe length and per-port write protection. All pin outputs are registered.
module sram_port_arbiter #(
    parameter int unsigned          NUM_PORTS     = 2,
    parameter int unsigned          ADDR_W        = 18,
    parameter int unsigned          DATA_W        = 8,
    parameter int unsigned          WAIT_STATES   = 1,
    parameter int unsigned          ARB_MODE      = 0,
    parameter logic [NUM_PORTS-1:0] WRITE_PROTECT = '0
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [NUM_PORTS-1:0]        port_req_i,
    input  logic [NUM_PORTS-1:0]        port_we_i,
    input  logic [NUM_PORTS*ADDR_W-1:0] port_addr_i,
    input  logic [NUM_PORTS*DATA_W-1:0] port_wdata_i,
    output logic [NUM_PORTS-1:0]        port_ack_o,
    output logic [DATA_W-1:0]           port_rdata_o,
    output logic                        busy_o,
    output logic                        sram_csn_o,
    output logic                        sram_oen_o,
    output logic                        sram_wen_o,
    output logic [ADDR_W-1:0]           sram_addr_o,
    output logic [DATA_W-1:0]           sram_dout_o,
    input  logic [DATA_W-1:0]           sram_din_i,
    output logic [DATA_W-1:0]           sram_data_t_o
);

    localparam int unsigned IdxW = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;

    typedef enum logic [1:0] {StIdle, StAccess, StRecover} state_e;

    state_e                 state_q, state_d;
    logic [3:0]             cnt_q, cnt_d;
    logic [IdxW-1:0]        grant_q, grant_d;
    logic [IdxW-1:0]        last_grant_q, last_grant_d;
    logic                   we_q, we_d;
    logic                   csn_q, csn_d;
    logic                   oen_q, oen_d;
    logic                   wen_q, wen_d;
    logic [DATA_W-1:0]      data_t_q, data_t_d;
    logic [ADDR_W-1:0]      addr_q, addr_d;
    logic [DATA_W-1:0]      dout_q, dout_d;
    logic [NUM_PORTS-1:0]   ack_q, ack_d;
    logic [DATA_W-1:0]      rdata_q, rdata_d;
    logic [IdxW-1:0]        win;

    always_comb begin
        logic        found;
        int unsigned cand;
        win   = '0;
        found = 1'b0;
        cand  = 0;
        if (ARB_MODE == 0) begin
            // Walk downwards so the lowest asserted index is the last one written.
            for (int i = NUM_PORTS - 1; i >= 0; i--) begin
                if (port_req_i[IdxW'(i)]) begin
                    win = IdxW'(i);
                end
            end
        end else begin
            for (int unsigned off = 1; off <= NUM_PORTS; off++) begin
                cand = (32'(last_grant_q) + off) % NUM_PORTS;
                if (!found && port_req_i[IdxW'(cand)]) begin
                    win   = IdxW'(cand);
                    found = 1'b1;
                end
            end
        end
    end

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        grant_d      = grant_q;
        last_grant_d = last_grant_q;
        we_d         = we_q;
        csn_d        = csn_q;
        oen_d        = oen_q;
        wen_d        = wen_q;
        data_t_d     = data_t_q;
        addr_d       = addr_q;
        dout_d       = dout_q;
        ack_d        = ack_q;
        rdata_d      = rdata_q;
        unique case (state_q)
            StIdle: begin
                if (|port_req_i) begin
                    grant_d      = win;
                    last_grant_d = win;
                    we_d         = port_we_i[win];
                    addr_d       = port_addr_i[win*ADDR_W +: ADDR_W];
                    cnt_d        = 4'(WAIT_STATES);
                    state_d      = StAccess;
                    if (!port_we_i[win]) begin
                        csn_d = 1'b0;
                        oen_d = 1'b0;
                    end else if (!WRITE_PROTECT[win]) begin
                        csn_d    = 1'b0;
                        wen_d    = 1'b0;
                        data_t_d = '0;
                        dout_d   = port_wdata_i[win*DATA_W +: DATA_W];
                    end
                end
            end
            StAccess: begin
                if (cnt_q != 4'd0) begin
                    cnt_d = cnt_q - 4'd1;
                end else begin
                    if (!we_q) begin
                        rdata_d = sram_din_i;
                    end
                    csn_d   = 1'b1;
                    oen_d   = 1'b1;
                    wen_d   = 1'b1;
                    ack_d   = NUM_PORTS'(1) << grant_q;
                    state_d = StRecover;
                end
            end
            StRecover: begin
                // Write data stays driven one cycle past wen for hold time.
                ack_d    = '0;
                data_t_d = '1;
                state_d  = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= StIdle;
            cnt_q        <= '0;
            grant_q      <= '0;
            last_grant_q <= IdxW'(NUM_PORTS - 1);
            we_q         <= 1'b0;
            csn_q        <= 1'b1;
            oen_q        <= 1'b1;
            wen_q        <= 1'b1;
            data_t_q     <= '1;
            addr_q       <= '0;
            dout_q       <= '0;
            ack_q        <= '0;
            rdata_q      <= '0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            grant_q      <= grant_d;
            last_grant_q <= last_grant_d;
            we_q         <= we_d;
            csn_q        <= csn_d;
            oen_q        <= oen_d;
            wen_q        <= wen_d;
            data_t_q     <= data_t_d;
            addr_q       <= addr_d;
            dout_q       <= dout_d;
            ack_q        <= ack_d;
            rdata_q      <= rdata_d;
        end
    end

    assign port_ack_o    = ack_q;
    assign port_rdata_o  = rdata_q;
    assign busy_o        = (state_q != StIdle);
    assign sram_csn_o    = csn_q;
    assign sram_oen_o    = oen_q;
    assign sram_wen_o    = wen_q;
    assign sram_addr_o   = addr_q;
    assign sram_dout_o   = dout_q;
    assign sram_data_t_o = data_t_q;

endmodule

// File: tb/tb_sram_port_arbiter.sv
// Bench for sram_port_arbiter: four instances cover timing, protection and both arbitration modes.
// Expected acks are queued when a request is issued and popped when an ack appears.
module tb_sram_port_arbiter;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic [7:0] ack;
        logic [7:0] rdata;
        int         k;
    } exp_t;
    exp_t sb[$];

    // Shared 2-port request buses (instances A and B), 3-port buses (C and D)
    logic [1:0]  p2_we;
    logic [35:0] p2_addr;
    logic [15:0] p2_wdata;
    logic [2:0]  p3_we;
    logic [53:0] p3_addr;
    logic [23:0] p3_wdata;

    logic [1:0]  a_req, a_ack, b_req, b_ack;
    logic [2:0]  c_req, c_ack, d_req, d_ack;
    logic [7:0]  a_rdata, b_rdata, c_rdata, d_rdata;
    logic        a_busy, b_busy, c_busy, d_busy;
    logic        a_csn, a_oen, a_wen, b_csn, b_oen, b_wen;
    logic        c_csn, c_oen, c_wen, d_csn, d_oen, d_wen;
    logic [17:0] a_saddr, b_saddr, c_saddr, d_saddr;
    logic [7:0]  a_dout, b_dout, c_dout, d_dout;
    logic [7:0]  a_din, b_din, c_din, d_din;
    logic [7:0]  a_dt, b_dt, c_dt, d_dt;
    logic [7:0]  b_mem [256];
    logic [7:0]  a_rd_model;
    logic [7:0]  b_rd_model;

    // Read-only pads return a pattern derived from the address
    assign a_din = a_saddr[7:0] ^ 8'hE0;
    assign c_din = c_saddr[7:0] ^ 8'hE0;
    assign d_din = d_saddr[7:0] ^ 8'hE0;
    assign b_din = b_mem[b_saddr[7:0]];

    always @(posedge clk) begin
        if (!b_csn && !b_wen) b_mem[b_saddr[7:0]] <= b_dout;
    end

    sram_port_arbiter #(.NUM_PORTS(2), .ADDR_W(18), .DATA_W(8), .WAIT_STATES(1), .ARB_MODE(0),
                        .WRITE_PROTECT(2'b00)) u_a (
        .clk(clk), .rst(rst), .port_req_i(a_req), .port_we_i(p2_we), .port_addr_i(p2_addr),
        .port_wdata_i(p2_wdata), .port_ack_o(a_ack), .port_rdata_o(a_rdata), .busy_o(a_busy),
        .sram_csn_o(a_csn), .sram_oen_o(a_oen), .sram_wen_o(a_wen), .sram_addr_o(a_saddr),
        .sram_dout_o(a_dout), .sram_din_i(a_din), .sram_data_t_o(a_dt)
    );

    sram_port_arbiter #(.NUM_PORTS(2), .ADDR_W(18), .DATA_W(8), .WAIT_STATES(0), .ARB_MODE(0),
                        .WRITE_PROTECT(2'b01)) u_b (
        .clk(clk), .rst(rst), .port_req_i(b_req), .port_we_i(p2_we), .port_addr_i(p2_addr),
        .port_wdata_i(p2_wdata), .port_ack_o(b_ack), .port_rdata_o(b_rdata), .busy_o(b_busy),
        .sram_csn_o(b_csn), .sram_oen_o(b_oen), .sram_wen_o(b_wen), .sram_addr_o(b_saddr),
        .sram_dout_o(b_dout), .sram_din_i(b_din), .sram_data_t_o(b_dt)
    );

    sram_port_arbiter #(.NUM_PORTS(3), .ADDR_W(18), .DATA_W(8), .WAIT_STATES(3), .ARB_MODE(0),
                        .WRITE_PROTECT(3'b000)) u_c (
        .clk(clk), .rst(rst), .port_req_i(c_req), .port_we_i(p3_we), .port_addr_i(p3_addr),
        .port_wdata_i(p3_wdata), .port_ack_o(c_ack), .port_rdata_o(c_rdata), .busy_o(c_busy),
        .sram_csn_o(c_csn), .sram_oen_o(c_oen), .sram_wen_o(c_wen), .sram_addr_o(c_saddr),
        .sram_dout_o(c_dout), .sram_din_i(c_din), .sram_data_t_o(c_dt)
    );

    sram_port_arbiter #(.NUM_PORTS(3), .ADDR_W(18), .DATA_W(8), .WAIT_STATES(3), .ARB_MODE(1),
                        .WRITE_PROTECT(3'b000)) u_d (
        .clk(clk), .rst(rst), .port_req_i(d_req), .port_we_i(p3_we), .port_addr_i(p3_addr),
        .port_wdata_i(p3_wdata), .port_ack_o(d_ack), .port_rdata_o(d_rdata), .busy_o(d_busy),
        .sram_csn_o(d_csn), .sram_oen_o(d_oen), .sram_wen_o(d_wen), .sram_addr_o(d_saddr),
        .sram_dout_o(d_dout), .sram_din_i(d_din), .sram_data_t_o(d_dt)
    );

    task automatic test_reset();
        n_checks++;
        if ({a_csn, a_oen, a_wen} !== 3'b111) begin
            n_fail++; $display("FAIL reset_strobes: got %b want 111", {a_csn, a_oen, a_wen});
        end
        n_checks++;
        if (a_dt !== 8'hFF) begin n_fail++; $display("FAIL reset_data_t: got %h want ff", a_dt); end
        n_checks++;
        if ({a_saddr, a_dout} !== 26'd0) begin
            n_fail++; $display("FAIL reset_addr_dout: got %h/%h want 0/0", a_saddr, a_dout);
        end
        n_checks++;
        if ({a_ack, a_rdata, a_busy} !== 11'd0) begin
            n_fail++; $display("FAIL reset_ack_rdata_busy: got %b/%h/%b want 0", a_ack, a_rdata, a_busy);
        end
    endtask

    task automatic test_single_read();
        exp_t e;
        int csn_low = 0;
        int oen_low = 0;
        p2_we = 2'b00;
        p2_addr[18 +: 18] = 18'h12345;
        sb.push_back('{ack: 8'h02, rdata: 8'hA5, k: 3});
        a_req = 2'b10;
        for (int k = 1; k <= 12; k++) begin
            @(negedge clk);
            if (!a_csn) csn_low++;
            if (!a_oen) oen_low++;
            if (k == 1) begin
                n_checks++;
                if (a_saddr !== 18'h12345) begin
                    n_fail++; $display("FAIL read_addr: got %h want 12345", a_saddr);
                end
            end
            if (a_ack != 2'b00) begin
                a_req = 2'b00;
                n_checks++;
                if (sb.size() == 0) begin
                    n_fail++; $display("FAIL read_unexpected_ack: got %b at %0d want none", a_ack, k);
                end else begin
                    e = sb.pop_front();
                    a_rd_model = e.rdata;
                    if ({6'd0, a_ack} !== e.ack || a_rdata !== e.rdata || k != e.k) begin
                        n_fail++;
                        $display("FAIL read_ack: got ack %b rdata %h k %0d want %h %h %0d",
                                 a_ack, a_rdata, k, e.ack, e.rdata, e.k);
                    end
                end
            end
        end
        n_checks++;
        if (sb.size() != 0) begin n_fail++; $display("FAIL read_timeout: %0d acks missing", sb.size()); end
        sb.delete();
        n_checks++;
        if (csn_low != 2 || oen_low != 2) begin
            n_fail++; $display("FAIL read_strobe_len: got csn %0d oen %0d want 2 2", csn_low, oen_low);
        end
    endtask

    task automatic test_back_to_back();
        exp_t e;
        int starts[$];
        logic csn_prev = 1'b1;
        p2_we = 2'b00;
        p2_addr[0 +: 18] = 18'h00020;
        sb.push_back('{ack: 8'h01, rdata: 8'hC0, k: 3});
        sb.push_back('{ack: 8'h01, rdata: 8'hD1, k: 7});
        a_req = 2'b01;
        for (int k = 1; k <= 16; k++) begin
            @(negedge clk);
            if (!a_csn && csn_prev) starts.push_back(k);
            csn_prev = a_csn;
            if (k == 1) p2_addr[0 +: 18] = 18'h00031;  // must not affect the access in flight
            if (k == 2) begin
                n_checks++;
                if (a_saddr !== 18'h00020) begin
                    n_fail++; $display("FAIL b2b_addr_latched: got %h want 00020", a_saddr);
                end
            end
            if (a_ack != 2'b00) begin
                n_checks++;
                if (sb.size() == 0) begin
                    n_fail++; $display("FAIL b2b_unexpected_ack: got %b at %0d want none", a_ack, k);
                end else begin
                    e = sb.pop_front();
                    a_rd_model = e.rdata;
                    if (sb.size() == 0) a_req = 2'b00;
                    if ({6'd0, a_ack} !== e.ack || a_rdata !== e.rdata || k != e.k) begin
                        n_fail++;
                        $display("FAIL b2b_ack: got ack %b rdata %h k %0d want %h %h %0d",
                                 a_ack, a_rdata, k, e.ack, e.rdata, e.k);
                    end
                end
            end else begin
                n_checks++;
                if (a_rdata !== a_rd_model) begin
                    n_fail++; $display("FAIL b2b_rdata_hold: got %h want %h at %0d", a_rdata, a_rd_model, k);
                end
            end
        end
        n_checks++;
        if (sb.size() != 0) begin n_fail++; $display("FAIL b2b_timeout: %0d acks missing", sb.size()); end
        sb.delete();
        n_checks++;
        if (starts.size() != 2 || starts[1] - starts[0] != 4) begin
            n_fail++; $display("FAIL b2b_spacing: got %0d starts, gap %0d want 2, 4", starts.size(),
                               (starts.size() == 2) ? starts[1] - starts[0] : -1);
        end
    endtask

    // Runs one 2-cycle-latency access on instance B and reports strobe activity.
    task automatic run_b(input logic [1:0] req, input string name,
                         output int csn_low, output int wen_low, output int dt_drv);
        exp_t e;
        csn_low = 0; wen_low = 0; dt_drv = 0;
        b_req = req;
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            if (!b_csn) csn_low++;
            if (!b_wen) wen_low++;
            if (b_dt != 8'hFF) dt_drv++;
            if (b_ack != 2'b00) begin
                b_req = 2'b00;
                n_checks++;
                if (sb.size() == 0) begin
                    n_fail++; $display("FAIL %s_unexpected_ack: got %b at %0d want none", name, b_ack, k);
                end else begin
                    e = sb.pop_front();
                    b_rd_model = e.rdata;
                    if ({6'd0, b_ack} !== e.ack || b_rdata !== e.rdata || k != e.k) begin
                        n_fail++;
                        $display("FAIL %s_ack: got ack %b rdata %h k %0d want %h %h %0d",
                                 name, b_ack, b_rdata, k, e.ack, e.rdata, e.k);
                    end
                end
            end
        end
        n_checks++;
        if (sb.size() != 0) begin n_fail++; $display("FAIL %s_timeout: ack missing", name); end
        sb.delete();
    endtask

    task automatic test_write();
        int csn_low, wen_low, dt_drv;
        p2_we = 2'b10;
        p2_addr[18 +: 18] = 18'h00010;
        p2_wdata[8 +: 8] = 8'h3C;
        sb.push_back('{ack: 8'h02, rdata: b_rd_model, k: 2});
        run_b(2'b10, "write", csn_low, wen_low, dt_drv);
        n_checks++;
        if (wen_low != 1 || dt_drv != 2) begin
            n_fail++; $display("FAIL write_strobes: got wen %0d data_t %0d want 1 2", wen_low, dt_drv);
        end
        n_checks++;
        if (b_mem[8'h10] !== 8'h3C) begin
            n_fail++; $display("FAIL write_mem: got %h want 3c", b_mem[8'h10]);
        end
    endtask

    task automatic test_write_protect();
        int csn_low, wen_low, dt_drv;
        p2_we = 2'b01;
        p2_addr[0 +: 18] = 18'h00010;
        p2_wdata[0 +: 8] = 8'hFF;
        sb.push_back('{ack: 8'h01, rdata: b_rd_model, k: 2});
        run_b(2'b01, "wprot", csn_low, wen_low, dt_drv);
        n_checks++;
        if (csn_low != 0 || wen_low != 0 || dt_drv != 0) begin
            n_fail++; $display("FAIL wprot_pins: got csn %0d wen %0d data_t %0d want 0 0 0",
                               csn_low, wen_low, dt_drv);
        end
        p2_we = 2'b00;
        sb.push_back('{ack: 8'h01, rdata: 8'h3C, k: 2});
        run_b(2'b01, "wprot_readback", csn_low, wen_low, dt_drv);
        n_checks++;
        if (csn_low != 1) begin
            n_fail++; $display("FAIL wprot_readback_csn: got %0d want 1", csn_low);
        end
    endtask

    task automatic test_arbitration(input logic rr);
        exp_t e;
        logic [2:0] ack;
        logic [7:0] rdata;
        string name = rr ? "rr" : "fixed";
        p3_we = 3'b000;
        p3_addr = {18'h00102, 18'h00101, 18'h00100};
        for (int g = 0; g < 4; g++) begin
            if (rr) sb.push_back('{ack: 8'd1 << (g % 3), rdata: 8'hE0 + 8'(g % 3), k: 5 + 6 * g});
            else    sb.push_back('{ack: 8'h01, rdata: 8'hE0, k: 5 + 6 * g});
        end
        if (rr) d_req = 3'b111; else c_req = 3'b111;
        for (int k = 1; k <= 32; k++) begin
            @(negedge clk);
            ack   = rr ? d_ack : c_ack;
            rdata = rr ? d_rdata : c_rdata;
            if (ack != 3'b000) begin
                n_checks++;
                if (sb.size() == 0) begin
                    n_fail++; $display("FAIL %s_unexpected_ack: got %b at %0d want none", name, ack, k);
                end else begin
                    e = sb.pop_front();
                    if (sb.size() == 0) begin c_req = 3'b000; d_req = 3'b000; end
                    if ({5'd0, ack} !== e.ack || rdata !== e.rdata || k != e.k) begin
                        n_fail++;
                        $display("FAIL %s_grant: got ack %b rdata %h k %0d want %h %h %0d",
                                 name, ack, rdata, k, e.ack, e.rdata, e.k);
                    end
                end
            end
        end
        n_checks++;
        if (sb.size() != 0) begin n_fail++; $display("FAIL %s_timeout: %0d acks missing", name, sb.size()); end
        sb.delete();
    endtask

    task automatic test_reset_mid_access();
        int stray = 0;
        p3_we = 3'b001;
        p3_addr[0 +: 18] = 18'h00055;
        p3_wdata[0 +: 8] = 8'h5A;
        d_req = 3'b001;
        repeat (2) @(negedge clk);
        n_checks++;
        if ({d_csn, d_oen, d_wen} !== 3'b010 || d_dt !== 8'h00 || d_busy !== 1'b1) begin
            n_fail++; $display("FAIL midrst_pre: got %b dt %h busy %b want 010 00 1",
                               {d_csn, d_oen, d_wen}, d_dt, d_busy);
        end
        #1 rst = 1'b1;
        #1;
        n_checks++;
        if ({d_csn, d_oen, d_wen} !== 3'b111 || d_dt !== 8'hFF || d_ack !== 3'b000) begin
            n_fail++; $display("FAIL midrst_async: got %b dt %h ack %b want 111 ff 000",
                               {d_csn, d_oen, d_wen}, d_dt, d_ack);
        end
        d_req = 3'b000;
        repeat (3) begin
            @(negedge clk);
            if (d_ack != 3'b000) stray++;
        end
        rst = 1'b0;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            if (d_ack != 3'b000 || d_busy) stray++;
        end
        n_checks++;
        if (stray != 0 || d_busy !== 1'b0) begin
            n_fail++; $display("FAIL midrst_after: got %0d stray ack/busy cycles, busy %b want 0 0",
                               stray, d_busy);
        end
    endtask

    initial begin
        rst = 1'b1;
        a_req = '0; b_req = '0; c_req = '0; d_req = '0;
        p2_we = '0; p2_addr = '0; p2_wdata = '0;
        p3_we = '0; p3_addr = '0; p3_wdata = '0;
        a_rd_model = '0; b_rd_model = '0;
        for (int i = 0; i < 256; i++) b_mem[i] = 8'h00;
        repeat (3) @(negedge clk);
        test_reset();
        rst = 1'b0;
        @(negedge clk);
        test_reset_mid_access();
        test_single_read();
        test_back_to_back();
        test_write();
        test_write_protect();
        test_arbitration(1'b0);
        test_arbitration(1'b1);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
